booth_multiplier: RTL

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/booth_multiplier_if.sv | 26 ++
 rtl/booth_recoder.sv | 45 ++++
 rtl/booth_multiplier.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit blocks.
// Holds the multiplier FSM state encoding and the Booth recoding operations.
// MUL_CNT_W sizes the step counter for the default operand width.
package mdu_pkg;

  localparam int MUL_PARALLELISM = 32;

  // Step counter width for a given operand width (counter runs from P+1 down to 1)
  function automatic int mul_cnt_w(input int p);
    return $clog2(p + 2);
  endfunction

  localparam int MUL_CNT_W = mul_cnt_w(MUL_PARALLELISM);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

endpackage

// File: rtl/booth_multiplier_if.sv
// Request/response bundle between a multiplier client and booth_multiplier.
// The master drives operands and start; the slave returns busy, done and product.
// No handshake beyond start/busy: a start seen while busy is simply dropped.
interface booth_multiplier_if #(
  parameter int PARALLELISM = 32
);

  logic                       usigned_n;
  logic [PARALLELISM-1:0]     multiplicand;
  logic [PARALLELISM-1:0]     multiplier;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic [2*PARALLELISM-1:0]   product;

  modport master (
    output usigned_n, multiplicand, multiplier, start,
    input  busy, done, product
  );

  modport slave (
    input  usigned_n, multiplicand, multiplier, start,
    output busy, done, product
  );

endinterface

// File: rtl/booth_recoder.sv
// Radix-2 Booth recoder: maps (b0, guard) to an operation and the addend for it.
// Purely combinational, zero latency.
// No backpressure; subtraction is returned as ~A with a carry-in of 1.
module booth_recoder
  import mdu_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         b0,
  input  logic         guard,
  input  logic [W-1:0] a,
  output logic [W:0]   addend,
  output logic         cin
);

  booth_op_t op;

  // Decode the multiplier bit pair into add / subtract / skip
  always_comb begin
    op = NOP;
    case ({b0, guard})
      2'b10:   op = SUB;
      2'b01:   op = ADD;
      default: op = NOP;
    endcase
  end

  // Sign-extend A by one bit to accumulator width and invert it for subtraction
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (op)
      ADD: addend = {a[W-1], a};
      SUB: begin
        addend = ~{a[W-1], a};
        cin    = 1'b1;
      end
      default: begin
        addend = '0;
        cin    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, PARALLELISM-bit operands.
// Latency: done pulses PARALLELISM+2 cycles after start is sampled (1 cycle for a
// zero operand when MUL_ZERO_BYPASS_EN is defined). start is ignored while busy.
module booth_multiplier
  import mdu_pkg::*;
#(
  parameter int PARALLELISM = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_multiplier_if.slave    bus
);

  // Operands carry one extra bit so unsigned values become non-negative signed values
  localparam int EW    = PARALLELISM + 1;
  localparam int AW    = PARALLELISM + 2;
  localparam int CNT_W = mul_cnt_w(PARALLELISM);

  mul_state_t state, state_nxt;

  logic [EW-1:0]            a_reg;
  logic [EW-1:0]            b_reg;
  logic [AW-1:0]            acc;
  logic                     guard;
  logic [CNT_W-1:0]         cnt;
  logic [2*PARALLELISM-1:0] product_reg;

  logic [EW-1:0]            a_ext;
  logic [EW-1:0]            b_ext;
  logic                     zero_op;
  logic                     accept;
  logic                     last_step;
  logic [AW-1:0]            addend;
  logic                     cin;
  logic [AW-1:0]            acc_sum;
  logic [AW-1:0]            acc_shr;
  logic [EW-1:0]            b_shr;

  assign a_ext = bus.usigned_n ? {1'b0, bus.multiplicand}
                               : {bus.multiplicand[PARALLELISM-1], bus.multiplicand};
  assign b_ext = bus.usigned_n ? {1'b0, bus.multiplier}
                               : {bus.multiplier[PARALLELISM-1], bus.multiplier};

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (a_ext == '0) || (b_ext == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign accept    = (state == IDLE) && bus.start;
  assign last_step = (state == RUN) && (cnt == CNT_W'(1));

  booth_recoder #(
    .W (EW)
  ) u_recoder (
    .b0     (b_reg[0]),
    .guard  (guard),
    .a      (a_reg),
    .addend (addend),
    .cin    (cin)
  );

  // Add/subtract then arithmetic shift of {acc, b_reg} right by one
  assign acc_sum = acc + addend + {{(AW-1){1'b0}}, cin};
  assign acc_shr = {acc_sum[AW-1], acc_sum[AW-1:1]};
  assign b_shr   = {acc_sum[0], b_reg[EW-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, Booth iteration and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      guard       <= 1'b0;
      cnt         <= '0;
      product_reg <= '0;
    end else if (accept) begin
      a_reg <= a_ext;
      b_reg <= b_ext;
      acc   <= '0;
      guard <= 1'b0;
      cnt   <= CNT_W'(PARALLELISM + 1);
      if (zero_op) begin
        product_reg <= '0;
      end
    end else if (state == RUN) begin
      acc   <= acc_shr;
      b_reg <= b_shr;
      guard <= b_reg[0];
      cnt   <= cnt - CNT_W'(1);
      if (last_step) begin
        product_reg <= {acc_shr[PARALLELISM-2:0], b_shr};
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_reg;

endmodule
